avalon_burst_master: RTL

AVALON_BURST_MASTER -- requirements
Module: avalon_burst_master

---
 rtl/avalon_pkg.sv | 14 +
 rtl/avalon_burst_master_if.sv | 47 ++++
 rtl/avalon_wait_watchdog.sv | 34 +++
 rtl/avalon_burst_master.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/avalon_pkg.sv
// rtl/avalon_pkg.sv - shared widths and FSM state encoding for the Avalon burst master
package avalon_pkg;
  localparam int AV_ADDR_W  = 30;
  localparam int AV_DATA_W  = 32;
  localparam int AV_BURST_W = 8;
  localparam int AV_BE_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/avalon_burst_master_if.sv
// rtl/avalon_burst_master_if.sv - command, beat streams, status and Avalon bus of avalon_burst_master
interface avalon_burst_master_if;
  import avalon_pkg::*;

  logic                  i_Cmd_Valid;
  logic                  o_Cmd_Ready;
  logic                  i_Cmd_Write;
  logic [AV_ADDR_W-1:0]  i_Cmd_Addr;
  logic [AV_BE_W-1:0]    i_Cmd_ByteEn;
  logic [AV_BURST_W-1:0] i_Cmd_Len;

  logic [AV_DATA_W-1:0]  i_WrData;
  logic                  i_WrData_Valid;
  logic                  o_WrData_Ready;

  logic [AV_DATA_W-1:0]  o_RdData;
  logic                  o_RdData_Valid;

  logic                  o_Busy;
  logic                  o_Done;
  logic                  o_Err;

  logic [AV_ADDR_W-1:0]  o_AV_Addr;
  logic [AV_BE_W-1:0]    o_AV_ByteEn;
  logic                  o_AV_Read;
  logic                  o_AV_Write;
  logic [AV_DATA_W-1:0]  o_AV_WriteData;
  logic [AV_DATA_W-1:0]  i_AV_ReadData;
  logic                  i_AV_WaitRequest;
  logic [AV_BURST_W-1:0] o_AV_BurstCount;

  modport master (
    input  i_Cmd_Valid, i_Cmd_Write, i_Cmd_Addr, i_Cmd_ByteEn, i_Cmd_Len,
    input  i_WrData, i_WrData_Valid, i_AV_ReadData, i_AV_WaitRequest,
    output o_Cmd_Ready, o_WrData_Ready, o_RdData, o_RdData_Valid,
    output o_Busy, o_Done, o_Err,
    output o_AV_Addr, o_AV_ByteEn, o_AV_Read, o_AV_Write, o_AV_WriteData, o_AV_BurstCount
  );

  modport slave (
    output i_Cmd_Valid, i_Cmd_Write, i_Cmd_Addr, i_Cmd_ByteEn, i_Cmd_Len,
    output i_WrData, i_WrData_Valid, i_AV_ReadData, i_AV_WaitRequest,
    input  o_Cmd_Ready, o_WrData_Ready, o_RdData, o_RdData_Valid,
    input  o_Busy, o_Done, o_Err,
    input  o_AV_Addr, o_AV_ByteEn, o_AV_Read, o_AV_Write, o_AV_WriteData, o_AV_BurstCount
  );
endinterface

// File: rtl/avalon_wait_watchdog.sv
// rtl/avalon_wait_watchdog.sv - counts consecutive stalled bus-request cycles and flags expiry
module avalon_wait_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bus_req,
  input  logic wait_request,
  output logic expired
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             stalled;

  assign stalled = bus_req && wait_request;
  // Expiry fires combinationally on the TIMEOUT_CYCLES-th stalled cycle itself.
  assign expired = stalled && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    count_d = '0;
    if (stalled && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/avalon_burst_master.sv
// rtl/avalon_burst_master.sv - Avalon-MM burst master: one command per burst, single-entry write beat register.
// Optional wait-request abort enabled by AVALON_BURST_MASTER_TIMEOUT_EN.
module avalon_burst_master
  import avalon_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  avalon_burst_master_if.master bus
);
  state_e                state_q, state_d;
  logic [AV_ADDR_W-1:0]  addr_q, addr_d;
  logic [AV_BE_W-1:0]    byteen_q, byteen_d;
  logic [AV_BURST_W-1:0] burst_q, burst_d;
  logic [AV_BURST_W-1:0] cnt_q, cnt_d;
  logic                  full_q, full_d;
  logic [AV_DATA_W-1:0]  wdata_q, wdata_d;
  logic                  rd_valid_q, rd_valid_d;

  logic                  cmd_fire;
  logic                  wr_accept;
  logic                  rd_req;
  logic                  rd_accept;
  logic [AV_BURST_W-1:0] loads_rem;
  logic                  wr_ready;
  logic                  wr_load;
  logic                  timeout_hit;

  assign cmd_fire  = (state_q == IDLE) && bus.i_Cmd_Valid;
  assign wr_accept = full_q && !bus.i_AV_WaitRequest;
  assign rd_req    = (state_q == READ) && (cnt_q != '0);
  assign rd_accept = rd_req && !bus.i_AV_WaitRequest;
  // Beats still to be pulled from the stream: the one parked in the register is already counted.
  assign loads_rem = cnt_q - AV_BURST_W'(full_q);
  assign wr_ready  = (state_q == WRITE) && (loads_rem != '0) && (!full_q || wr_accept);
  assign wr_load   = wr_ready && bus.i_WrData_Valid;

`ifdef AVALON_BURST_MASTER_TIMEOUT_EN
  avalon_wait_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk         (i_Clk),
    .rst_n       (i_Rst_n),
    .bus_req     (full_q || rd_req),
    .wait_request(bus.i_AV_WaitRequest),
    .expired     (timeout_hit)
  );
`else
  logic unused_timeout_cfg;
  assign timeout_hit        = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      byteen_q   <= '0;
      burst_q    <= '0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      wdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      byteen_q   <= byteen_d;
      burst_q    <= burst_d;
      cnt_q      <= cnt_d;
      full_q     <= full_d;
      wdata_q    <= wdata_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    byteen_d   = byteen_q;
    burst_d    = burst_q;
    cnt_d      = cnt_q;
    full_d     = full_q;
    wdata_d    = wdata_q;
    rd_valid_d = rd_accept;

    unique case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          addr_d   = bus.i_Cmd_Addr;
          byteen_d = bus.i_Cmd_ByteEn;
          burst_d  = bus.i_Cmd_Len;
          cnt_d    = bus.i_Cmd_Len;
          if (bus.i_Cmd_Len == '0) begin
            state_d = DONE;
          end else if (bus.i_Cmd_Write) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      WRITE: begin
        if (wr_accept) begin
          cnt_d  = cnt_q - 1'b1;
          full_d = 1'b0;
        end
        if (wr_load) begin
          full_d  = 1'b1;
          wdata_d = bus.i_WrData;
        end
        if (wr_accept && (cnt_q == AV_BURST_W'(1))) begin
          state_d = DONE;
        end
      end
      READ: begin
        if (rd_accept) begin
          cnt_d = cnt_q - 1'b1;
        end
        // Leave once the final datum is on o_RdData.
        if (rd_valid_q && (cnt_q == '0)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (timeout_hit) begin
      state_d    = IDLE;
      cnt_d      = '0;
      full_d     = 1'b0;
      rd_valid_d = 1'b0;
    end
  end

  always_comb begin
    bus.o_Cmd_Ready     = (state_q == IDLE) && i_Rst_n;
    bus.o_WrData_Ready  = wr_ready;
    bus.o_RdData        = rd_valid_q ? bus.i_AV_ReadData : '0;
    bus.o_RdData_Valid  = rd_valid_q;
    bus.o_Busy          = (state_q != IDLE);
    bus.o_Done          = (state_q == DONE);
    bus.o_Err           = timeout_hit;
    bus.o_AV_Addr       = addr_q;
    bus.o_AV_ByteEn     = byteen_q;
    bus.o_AV_BurstCount = burst_q;
    bus.o_AV_Write      = full_q;
    bus.o_AV_Read       = rd_req;
    bus.o_AV_WriteData  = wdata_q;
  end
endmodule
